game_logic: RTL and testbench

//  Snake game core plus pixel colour generator for an 800x600 VGA frame.
//  The block keeps the snake body, the food cell and the game state.
//  It moves the snake one grid cell per mover pulse, in the direction given by accion.
//  For each PixelX/PixelY supplied by the VGA timing block, it returns an 8-bit RGB332 colour.
//  It sits between the direction state machine (accion, mover) and the VGA output register.

---
 rtl/game_logic.sv | 140 ++++++++++++++
 tb/tb_game_logic.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_logic.sv
// Snake game core with a registered RGB332 pixel generator for an 800x600 frame.
// Optional FOOD_BLINK_EN: when defined, the food is drawn only while clk_reduced is high.
module game_logic #(
  parameter int CELL     = 20,
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_reduced,
  input  logic        mover,
  input  logic [10:0] PixelX,
  input  logic [10:0] PixelY,
  input  logic        izquierda,
  input  logic        derecha,
  input  logic        arriba,
  input  logic        abajo,
  input  logic [2:0]  accion,
  output logic [2:0]  RObtenido,
  output logic [2:0]  GObtenido,
  output logic [1:0]  BObtenido
);

  typedef enum logic {PLAY, OVER} state_t;

  localparam logic [5:0] INIT_X = 6'(GRID_W / 2);
  localparam logic [4:0] INIT_Y = 5'(GRID_H / 2);
  localparam logic [5:0] FOOD_X = 6'(GRID_W * 3 / 4);

  state_t     state;
  logic [5:0] seg_x [MAX_LEN];
  logic [4:0] seg_y [MAX_LEN];
  logic [4:0] len;
  logic [5:0] food_x;
  logic [4:0] food_y;
  logic [15:0] lfsr;

  logic       move_req, restart, oob, self_hit, eat;
  logic [5:0] nh_x, fx_raw, fx_new;
  logic [4:0] nh_y, fy_raw, fy_new;

  assign move_req = mover && (state == PLAY) && (accion >= 3'd1) && (accion <= 3'd4);
  assign restart  = (state == OVER) && (arriba || abajo || izquierda || derecha);

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    nh_x     = seg_x[0];
    nh_y     = seg_y[0];
    oob      = 1'b0;
    self_hit = 1'b0;
    case (accion)
      3'd1: if (seg_y[0] == 5'd0)              oob = 1'b1; else nh_y = seg_y[0] - 5'd1;
      3'd2: if (seg_y[0] == 5'(GRID_H - 1))    oob = 1'b1; else nh_y = seg_y[0] + 5'd1;
      3'd3: if (seg_x[0] == 6'd0)              oob = 1'b1; else nh_x = seg_x[0] - 6'd1;
      3'd4: if (seg_x[0] == 6'(GRID_W - 1))    oob = 1'b1; else nh_x = seg_x[0] + 6'd1;
      default: ;
    endcase
    // The current tail vacates its cell on this move, so it is not a collision target.
    for (int i = 0; i < MAX_LEN - 1; i++) begin
      if ((5'(i) < len - 5'd1) && (seg_x[i] == nh_x) && (seg_y[i] == nh_y)) self_hit = 1'b1;
    end
    eat    = (nh_x == food_x) && (nh_y == food_y);
    fx_raw = lfsr[5:0];
    fy_raw = lfsr[12:8];
    fx_new = (fx_raw >= 6'(GRID_W)) ? fx_raw - 6'(GRID_W) : fx_raw;
    fy_new = (fy_raw >= 5'(GRID_H)) ? fy_raw - 5'(GRID_H) : fy_raw;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) lfsr <= 16'hACE1;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // NOTE: the segment array is reset in full so unused slots never hold X that could leak into compares.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= (i < INIT_LEN) ? INIT_X - 6'(i) : 6'd0;
        seg_y[i] <= (i < INIT_LEN) ? INIT_Y : 5'd0;
      end
      len    <= 5'(INIT_LEN);
      food_x <= FOOD_X;
      food_y <= INIT_Y;
      state  <= PLAY;
    end else if (move_req) begin
      if (oob || self_hit) begin
        state <= OVER;
      end else begin
        for (int i = MAX_LEN - 1; i > 0; i--) begin
          seg_x[i] <= seg_x[i-1];
          seg_y[i] <= seg_y[i-1];
        end
        seg_x[0] <= nh_x;
        seg_y[0] <= nh_y;
        if (eat) begin
          // Extending len keeps the old tail, which the shift already moved one slot down.
          len    <= (len == 5'(MAX_LEN)) ? len : len + 5'd1;
          food_x <= fx_new;
          food_y <= fy_new;
        end
      end
    end
  end

  logic [10:0] cx, cy;
  logic        visible, head_px, body_px, food_px, food_vis;

`ifdef FOOD_BLINK_EN
  assign food_vis = clk_reduced;
`else
  logic unused_clk_reduced;
  assign unused_clk_reduced = clk_reduced;
  assign food_vis = 1'b1;
`endif

  always_comb begin
    cx      = PixelX / 11'(CELL);
    cy      = PixelY / 11'(CELL);
    visible = (PixelX < 11'(GRID_W * CELL)) && (PixelY < 11'(GRID_H * CELL));
    head_px = (cx == {5'd0, seg_x[0]}) && (cy == {6'd0, seg_y[0]});
    food_px = (cx == {5'd0, food_x}) && (cy == {6'd0, food_y}) && food_vis;
    body_px = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((5'(i) < len) && (cx == {5'd0, seg_x[i]}) && (cy == {6'd0, seg_y[i]})) body_px = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !visible)  {RObtenido, GObtenido, BObtenido} <= 8'h00;
    else if (state == OVER) {RObtenido, GObtenido, BObtenido} <= {3'd7, 3'd0, 2'd3};
    else if (head_px)     {RObtenido, GObtenido, BObtenido} <= {3'd7, 3'd7, 2'd0};
    else if (body_px)     {RObtenido, GObtenido, BObtenido} <= {3'd0, 3'd7, 2'd0};
    else if (food_px)     {RObtenido, GObtenido, BObtenido} <= {3'd7, 3'd0, 2'd0};
    else                  {RObtenido, GObtenido, BObtenido} <= 8'h00;
  end

endmodule

// File: tb/tb_game_logic.sv
// Self-checking bench for game_logic: directed scenarios plus a randomized run against a queue-based model.
module tb_game_logic;

  logic        clk = 1'b0;
  logic        rst, clk_reduced, mover, izquierda, derecha, arriba, abajo;
  logic [10:0] PixelX, PixelY;
  logic [2:0]  accion;
  logic [2:0]  RObtenido, GObtenido;
  logic [1:0]  BObtenido;

  int tests = 0;
  int fails = 0;

  localparam logic [7:0] C_HEAD = 8'hFC, C_BODY = 8'h1C, C_FOOD = 8'hE0, C_OVER = 8'hE3, C_NONE = 8'h00;

  game_logic dut (
    .clk(clk), .rst(rst), .clk_reduced(clk_reduced), .mover(mover),
    .PixelX(PixelX), .PixelY(PixelY),
    .izquierda(izquierda), .derecha(derecha), .arriba(arriba), .abajo(abajo),
    .accion(accion), .RObtenido(RObtenido), .GObtenido(GObtenido), .BObtenido(BObtenido)
  );

  always #5 clk = ~clk;

  // Reference model: snake as a queue of cells, head at index 0.
  int   qx[$], qy[$];
  int   fx, fy;
  bit   over;
  logic [15:0] lfsr_m;

  always @(posedge clk) begin
    if (rst) lfsr_m <= 16'hACE1;
    else     lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  task automatic model_init();
    qx = '{20, 19, 18};
    qy = '{15, 15, 15};
    fx = 30; fy = 15; over = 0;
  endtask

  task automatic model_move(input int act);
    int  nx, ny;
    bit  eat;
    nx = qx[0]; ny = qy[0];
    if (over) return;
    case (act)
      1: ny = ny - 1;
      2: ny = ny + 1;
      3: nx = nx - 1;
      4: nx = nx + 1;
      default: return;
    endcase
    if (nx < 0 || nx >= 40 || ny < 0 || ny >= 30) begin over = 1; return; end
    for (int i = 0; i < qx.size() - 1; i++)
      if (qx[i] == nx && qy[i] == ny) begin over = 1; return; end
    eat = (nx == fx) && (ny == fy);
    qx.push_front(nx); qy.push_front(ny);
    if (!(eat && qx.size() <= 16)) begin void'(qx.pop_back()); void'(qy.pop_back()); end
    if (eat) begin
      fx = int'(lfsr_m & 16'h003F); if (fx >= 40) fx -= 40;
      fy = int'((lfsr_m >> 8) & 16'h001F); if (fy >= 30) fy -= 30;
    end
  endtask

  function automatic logic [7:0] model_colour(input int px, input int py, input logic cr);
    int cx, cy;
    bit fvis;
    if (px >= 800 || py >= 600) return C_NONE;
    if (over) return C_OVER;
    cx = px / 20; cy = py / 20;
    if (qx[0] == cx && qy[0] == cy) return C_HEAD;
    for (int i = 1; i < qx.size(); i++)
      if (qx[i] == cx && qy[i] == cy) return C_BODY;
`ifdef FOOD_BLINK_EN
    fvis = cr;
`else
    fvis = 1;
`endif
    if (fx == cx && fy == cy && fvis) return C_FOOD;
    return C_NONE;
  endfunction

  // One clock: apply inputs at a falling edge, advance the model, sample the colour at the next falling edge.
  task automatic drive(input logic r, input logic mv, input logic [2:0] act, input logic [3:0] btn,
                       input int px, input int py, input logic cr,
                       output logic [7:0] got, output logic [7:0] exp);
    rst = r; mover = mv; accion = act;
    {arriba, abajo, izquierda, derecha} = btn;
    PixelX = 11'(px); PixelY = 11'(py); clk_reduced = cr;
    if (r) begin
      exp = C_NONE;
      model_init();
    end else begin
      exp = model_colour(px, py, cr);
      if (over && btn != 4'd0) model_init();
      else if (mv)             model_move(int'(act));
    end
    @(negedge clk);
    got = {RObtenido, GObtenido, BObtenido};
  endtask

  task automatic do_reset();
    logic [7:0] got, exp;
    drive(1, 0, 0, 0, 410, 310, 1, got, exp);
    drive(1, 0, 0, 0, 410, 310, 1, got, exp);
  endtask

  task automatic test_reset();
    logic [7:0] got, exp;
    drive(1, 0, 0, 0, 410, 310, 1, got, exp);
    drive(1, 0, 0, 0, 410, 310, 1, got, exp);
    tests++; if (got !== C_NONE) begin fails++; $display("FAIL reset_colour got=%h exp=%h", got, C_NONE); end
    drive(0, 0, 0, 0, 410, 310, 1, got, exp);
    tests++; if (got !== C_HEAD || exp !== C_HEAD) begin fails++; $display("FAIL reset_head got=%h exp=%h", got, C_HEAD); end
    drive(0, 0, 0, 0, 370, 310, 1, got, exp);
    tests++; if (got !== C_BODY) begin fails++; $display("FAIL reset_body got=%h exp=%h", got, C_BODY); end
    drive(0, 0, 0, 0, 610, 310, 1, got, exp);
    tests++; if (got !== C_FOOD) begin fails++; $display("FAIL reset_food got=%h exp=%h", got, C_FOOD); end
    drive(0, 0, 0, 0, 350, 310, 1, got, exp);
    tests++; if (got !== C_NONE) begin fails++; $display("FAIL reset_background got=%h exp=%h", got, C_NONE); end
  endtask

  task automatic test_eat();
    logic [7:0] got, exp;
    do_reset();
    for (int i = 0; i < 10; i++) drive(0, 1, 3'd4, 0, 0, 0, 1, got, exp);
    drive(0, 0, 0, 0, 610, 310, 1, got, exp);
    tests++; if (got !== C_HEAD) begin fails++; $display("FAIL eat_head got=%h exp=%h", got, C_HEAD); end
    drive(0, 0, 0, 0, 545, 310, 1, got, exp);
    tests++; if (got !== C_BODY) begin fails++; $display("FAIL eat_grown_tail got=%h exp=%h", got, C_BODY); end
    drive(0, 0, 0, 0, 525, 310, 1, got, exp);
    tests++; if (got !== exp) begin fails++; $display("FAIL eat_past_tail got=%h exp=%h", got, exp); end
    drive(0, 0, 0, 0, fx * 20 + 7, fy * 20 + 7, 1, got, exp);
    tests++; if (got !== exp) begin fails++; $display("FAIL eat_new_food got=%h exp=%h", got, exp); end
  endtask

  task automatic test_wall();
    logic [7:0] got, exp;
    do_reset();
    for (int i = 0; i < 15; i++) drive(0, 1, 3'd1, 0, 410, 10, 1, got, exp);
    drive(0, 1, 3'd1, 0, 410, 10, 1, got, exp);
    tests++; if (got !== C_HEAD) begin fails++; $display("FAIL wall_head_at_top got=%h exp=%h", got, C_HEAD); end
    drive(0, 0, 0, 0, 5, 5, 1, got, exp);
    tests++; if (got !== C_OVER) begin fails++; $display("FAIL wall_over got=%h exp=%h", got, C_OVER); end
    drive(0, 1, 3'd2, 0, 900, 5, 1, got, exp);
    tests++; if (got !== C_NONE) begin fails++; $display("FAIL over_offscreen got=%h exp=%h", got, C_NONE); end
    drive(0, 0, 0, 0, 410, 10, 1, got, exp);
    tests++; if (got !== C_OVER) begin fails++; $display("FAIL over_frozen got=%h exp=%h", got, C_OVER); end
  endtask

  task automatic test_restart();
    logic [7:0] got, exp;
    drive(0, 0, 0, 4'b1000, 0, 0, 1, got, exp);
    drive(0, 0, 0, 0, 410, 310, 1, got, exp);
    tests++; if (got !== C_HEAD) begin fails++; $display("FAIL restart_head got=%h exp=%h", got, C_HEAD); end
    drive(0, 0, 0, 0, 610, 310, 1, got, exp);
    tests++; if (got !== C_FOOD) begin fails++; $display("FAIL restart_food got=%h exp=%h", got, C_FOOD); end
    drive(0, 0, 0, 4'b0001, 370, 310, 1, got, exp);
    drive(0, 0, 0, 0, 370, 310, 1, got, exp);
    tests++; if (got !== C_BODY) begin fails++; $display("FAIL play_button_ignored got=%h exp=%h", got, C_BODY); end
  endtask

  task automatic test_ignored();
    logic [7:0] got, exp;
    do_reset();
    drive(0, 1, 3'd0, 0, 0, 0, 1, got, exp);
    drive(0, 0, 3'd4, 0, 0, 0, 1, got, exp);
    drive(0, 1, 3'd6, 0, 0, 0, 1, got, exp);
    drive(0, 0, 0, 0, 410, 310, 1, got, exp);
    tests++; if (got !== C_HEAD) begin fails++; $display("FAIL ignored_head got=%h exp=%h", got, C_HEAD); end
    drive(0, 0, 0, 0, 430, 310, 1, got, exp);
    tests++; if (got !== C_NONE) begin fails++; $display("FAIL ignored_no_advance got=%h exp=%h", got, C_NONE); end
    drive(0, 0, 0, 0, 900, 310, 1, got, exp);
    tests++; if (got !== C_NONE) begin fails++; $display("FAIL offscreen_x got=%h exp=%h", got, C_NONE); end
    drive(0, 0, 0, 0, 410, 600, 1, got, exp);
    tests++; if (got !== C_NONE) begin fails++; $display("FAIL offscreen_y got=%h exp=%h", got, C_NONE); end
  endtask

  task automatic test_self_collision();
    logic [7:0] got, exp;
    do_reset();
    drive(0, 1, 3'd3, 0, 0, 0, 1, got, exp);
    drive(0, 0, 0, 0, 410, 310, 1, got, exp);
    tests++; if (got !== C_OVER) begin fails++; $display("FAIL reverse_into_body got=%h exp=%h", got, C_OVER); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got, exp;
    do_reset();
    drive(0, 1, 3'd4, 0, 430, 310, 1, got, exp);
    tests++; if (got !== C_NONE) begin fails++; $display("FAIL same_cycle_pre_move got=%h exp=%h", got, C_NONE); end
    drive(0, 0, 0, 0, 430, 310, 1, got, exp);
    tests++; if (got !== C_HEAD) begin fails++; $display("FAIL same_cycle_post_move got=%h exp=%h", got, C_HEAD); end
  endtask

  task automatic test_blink();
    logic [7:0] got, exp;
    do_reset();
    drive(0, 0, 0, 0, 610, 310, 0, got, exp);
`ifdef FOOD_BLINK_EN
    tests++; if (got !== C_NONE) begin fails++; $display("FAIL blink_low got=%h exp=%h", got, C_NONE); end
`else
    tests++; if (got !== C_FOOD) begin fails++; $display("FAIL blink_ignored got=%h exp=%h", got, C_FOOD); end
`endif
    drive(0, 0, 0, 0, 610, 310, 1, got, exp);
    tests++; if (got !== C_FOOD) begin fails++; $display("FAIL blink_high got=%h exp=%h", got, C_FOOD); end
  endtask

  task automatic test_random();
    logic [7:0] got, exp;
    logic [3:0] btn;
    int px, py, cx, cy;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      btn = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      if ($urandom_range(0, 3) == 0) begin
        px = $urandom_range(0, 1000);
        py = $urandom_range(0, 700);
      end else begin
        cx = qx[0] + $urandom_range(0, 6) - 3;
        cy = qy[0] + $urandom_range(0, 6) - 3;
        if (cx < 0) cx = 0;
        if (cy < 0) cy = 0;
        px = cx * 20 + $urandom_range(0, 19);
        py = cy * 20 + $urandom_range(0, 19);
      end
      drive(0, 1'($urandom), 3'($urandom_range(0, 5) == 0 ? $urandom_range(0, 7) : $urandom_range(1, 4)),
            btn, px, py, 1'($urandom), got, exp);
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL random_%0d px=%0d py=%0d got=%h exp=%h", n, px, py, got, exp);
      end
    end
  endtask

  initial begin
    rst = 1; clk_reduced = 0; mover = 0; accion = 0; PixelX = 0; PixelY = 0;
    izquierda = 0; derecha = 0; arriba = 0; abajo = 0;
    @(negedge clk);
    test_reset();
    test_eat();
    test_wall();
    test_restart();
    test_ignored();
    test_self_collision();
    test_back_to_back();
    test_blink();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
